// File: rtl/apb3_pkg.sv
// apb3_pkg
// Shared types and helpers for the APB3 master bridge.
//   - apb_state_t : bridge FSM states (IDLE, SETUP, ACCESS, RESP)
//   - apb_rsp_t   : captured response {rdata, err, timeout}
//   - slave_index : address -> raw region number (addr >> region_bits)
package apb3_pkg;

    localparam int APB_MAX_ADDR_W = 64;
    localparam int APB_MAX_DATA_W = 32;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2,
        RESP   = 2'd3
    } apb_state_t;

    typedef struct packed {
        logic [APB_MAX_DATA_W-1:0] rdata;
        logic                      err;
        logic                      timeout;
    } apb_rsp_t;

    // Returns the whole region number rather than just the low index bits,
    // so that addresses above the last populated region can be flagged as
    // decode errors even when NUM_SLAVES is a power of two.
    function automatic int unsigned slave_index(input logic [APB_MAX_ADDR_W-1:0] addr,
                                                input int unsigned region_bits);
        return 32'(addr >> region_bits);
    endfunction

endpackage

// File: rtl/apb3_addr_decode.sv
// apb3_addr_decode
// Combinational address decoder for the APB3 master bridge.
//   addr       in  ADDR_WIDTH  command address
//   idx        out IDX_W       slave index (low bits of the region number)
//   decode_err out 1           address lies beyond the last slave region
module apb3_addr_decode
    import apb3_pkg::*;
#(
    parameter int NUM_SLAVES  = 4,
    parameter int ADDR_WIDTH  = 32,
    parameter int REGION_BITS = 12,
    parameter int IDX_W       = 2
) (
    input  logic [ADDR_WIDTH-1:0] addr,
    output logic [IDX_W-1:0]      idx,
    output logic                  decode_err
);

    logic [APB_MAX_ADDR_W-1:0] addr_ext;
    int unsigned               region;

    assign addr_ext   = APB_MAX_ADDR_W'(addr);
    assign region     = slave_index(addr_ext, REGION_BITS);
    assign idx        = IDX_W'(region);
    // Any address bit above the populated regions makes the access illegal.
    assign decode_err = (region >= 32'(NUM_SLAVES));

endmodule

// File: rtl/apb3_master_bridge.sv
// apb3_master_bridge
// Converts a valid/ready command stream into APB3 transfers on NUM_SLAVES
// address-decoded slaves, one transfer in flight. Handles PREADY wait states,
// PSLVERR, decode errors and an optional wait-state timeout.
//   PCLK, PRESETn                 clock, synchronous active-low reset
//   cmd_valid/ready/addr/write/wdata   command channel (ready only in IDLE)
//   rsp_valid/ready/rdata/err/timeout  response channel (registered)
//   PSEL, PENABLE, PADDR, PWRITE, PWDATA  APB request (registered)
//   PRDATA, PREADY, PSLVERR       per-slave APB return signals
module apb3_master_bridge
    import apb3_pkg::*;
#(
    parameter int NUM_SLAVES     = 4,
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int REGION_BITS    = 12,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic                             PCLK,
    input  logic                             PRESETn,
    input  logic                             cmd_valid,
    output logic                             cmd_ready,
    input  logic [ADDR_WIDTH-1:0]            cmd_addr,
    input  logic                             cmd_write,
    input  logic [DATA_WIDTH-1:0]            cmd_wdata,
    output logic                             rsp_valid,
    input  logic                             rsp_ready,
    output logic [DATA_WIDTH-1:0]            rsp_rdata,
    output logic                             rsp_err,
    output logic                             rsp_timeout,
    output logic [NUM_SLAVES-1:0]            PSEL,
    output logic                             PENABLE,
    output logic [ADDR_WIDTH-1:0]            PADDR,
    output logic                             PWRITE,
    output logic [DATA_WIDTH-1:0]            PWDATA,
    input  logic [NUM_SLAVES*DATA_WIDTH-1:0] PRDATA,
    input  logic [NUM_SLAVES-1:0]            PREADY,
    input  logic [NUM_SLAVES-1:0]            PSLVERR
);

    localparam int IDX_W = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;
    localparam int CNT_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

    apb_state_t              state_reg, state_next;
    logic [NUM_SLAVES-1:0]   psel_reg, psel_next;
    logic                    penable_reg, penable_next;
    logic [ADDR_WIDTH-1:0]   paddr_reg, paddr_next;
    logic                    pwrite_reg, pwrite_next;
    logic [DATA_WIDTH-1:0]   pwdata_reg, pwdata_next;
    logic [IDX_W-1:0]        idx_reg, idx_next;
    logic [CNT_W-1:0]        cnt_reg, cnt_next;
    logic [CNT_W-1:0]        cnt_inc;
    logic                    rsp_valid_reg, rsp_valid_next;
    apb_rsp_t                rsp_reg, rsp_next;

    logic [IDX_W-1:0]        dec_idx;
    logic                    dec_err;

    logic [DATA_WIDTH-1:0]   prdata_slice [NUM_SLAVES];
    logic [DATA_WIDTH-1:0]   sel_rdata;
    logic                    sel_ready;
    logic                    sel_err;

    apb3_addr_decode #(
        .NUM_SLAVES (NUM_SLAVES),
        .ADDR_WIDTH (ADDR_WIDTH),
        .REGION_BITS(REGION_BITS),
        .IDX_W      (IDX_W)
    ) u_decode (
        .addr      (cmd_addr),
        .idx       (dec_idx),
        .decode_err(dec_err)
    );

    genvar gi;
    generate
        for (gi = 0; gi < NUM_SLAVES; gi++) begin : g_prdata
            assign prdata_slice[gi] = PRDATA[gi*DATA_WIDTH +: DATA_WIDTH];
        end
    endgenerate

    // Only the slave latched at accept time is ever looked at.
    assign sel_rdata = prdata_slice[idx_reg];
    assign sel_ready = PREADY[idx_reg];
    assign sel_err   = PSLVERR[idx_reg];
    assign cnt_inc   = cnt_reg + 1'b1;

    always_comb begin
        state_next     = state_reg;
        psel_next      = psel_reg;
        penable_next   = penable_reg;
        paddr_next     = paddr_reg;
        pwrite_next    = pwrite_reg;
        pwdata_next    = pwdata_reg;
        idx_next       = idx_reg;
        cnt_next       = cnt_reg;
        rsp_valid_next = rsp_valid_reg;
        rsp_next       = rsp_reg;

        case (state_reg)
            IDLE: begin
                if (cmd_valid) begin
                    paddr_next  = cmd_addr;
                    pwrite_next = cmd_write;
                    pwdata_next = cmd_wdata;
                    idx_next    = dec_idx;
                    cnt_next    = '0;
                    if (dec_err) begin
                        // No bus activity: answer with an error straight away.
                        rsp_next       = '{rdata: '0, err: 1'b1, timeout: 1'b0};
                        rsp_valid_next = 1'b1;
                        state_next     = RESP;
                    end else begin
                        psel_next  = NUM_SLAVES'(1) << dec_idx;
                        state_next = SETUP;
                    end
                end
            end
            SETUP: begin
                penable_next = 1'b1;
                state_next   = ACCESS;
            end
            ACCESS: begin
                if (sel_ready) begin
                    rsp_next.rdata   = pwrite_reg ? '0 : APB_MAX_DATA_W'(sel_rdata);
                    rsp_next.err     = sel_err;
                    rsp_next.timeout = 1'b0;
                    psel_next        = '0;
                    penable_next     = 1'b0;
                    rsp_valid_next   = 1'b1;
                    state_next       = RESP;
                end else begin
                    // Saturate rather than wrap when the timeout is disabled.
                    if (cnt_reg != '1) begin
                        cnt_next = cnt_inc;
                    end
                    if ((TIMEOUT_CYCLES != 0) && (cnt_inc == CNT_W'(TIMEOUT_CYCLES))) begin
                        rsp_next       = '{rdata: '0, err: 1'b1, timeout: 1'b1};
                        psel_next      = '0;
                        penable_next   = 1'b0;
                        rsp_valid_next = 1'b1;
                        state_next     = RESP;
                    end
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    rsp_valid_next = 1'b0;
                    cnt_next       = '0;
                    state_next     = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge PCLK) begin
        if (!PRESETn) begin
            state_reg     <= IDLE;
            psel_reg      <= '0;
            penable_reg   <= 1'b0;
            paddr_reg     <= '0;
            pwrite_reg    <= 1'b0;
            pwdata_reg    <= '0;
            idx_reg       <= '0;
            cnt_reg       <= '0;
            rsp_valid_reg <= 1'b0;
            rsp_reg       <= '0;
        end else begin
            state_reg     <= state_next;
            psel_reg      <= psel_next;
            penable_reg   <= penable_next;
            paddr_reg     <= paddr_next;
            pwrite_reg    <= pwrite_next;
            pwdata_reg    <= pwdata_next;
            idx_reg       <= idx_next;
            cnt_reg       <= cnt_next;
            rsp_valid_reg <= rsp_valid_next;
            rsp_reg       <= rsp_next;
        end
    end

    assign cmd_ready   = (state_reg == IDLE);
    assign rsp_valid   = rsp_valid_reg;
    assign rsp_rdata   = rsp_reg.rdata[DATA_WIDTH-1:0];
    assign rsp_err     = rsp_reg.err;
    assign rsp_timeout = rsp_reg.timeout;
    assign PSEL        = psel_reg;
    assign PENABLE     = penable_reg;
    assign PADDR       = paddr_reg;
    assign PWRITE      = pwrite_reg;
    assign PWDATA      = pwdata_reg;

endmodule

// File: tb/tb_apb3_master_bridge.sv
// Self-checking bench for apb3_master_bridge (NUM_SLAVES=4, TIMEOUT_CYCLES=8).
// Expected responses are pushed to a scoreboard queue when each command is
// issued and popped when the bridge presents rsp_valid.
module tb_apb3_master_bridge;

    logic         PCLK;
    logic         PRESETn;
    logic         cmd_valid;
    logic         cmd_ready;
    logic [31:0]  cmd_addr;
    logic         cmd_write;
    logic [31:0]  cmd_wdata;
    logic         rsp_valid;
    logic         rsp_ready;
    logic [31:0]  rsp_rdata;
    logic         rsp_err;
    logic         rsp_timeout;
    logic [3:0]   PSEL;
    logic         PENABLE;
    logic [31:0]  PADDR;
    logic         PWRITE;
    logic [31:0]  PWDATA;
    logic [127:0] PRDATA;
    logic [3:0]   PREADY;
    logic [3:0]   PSLVERR;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        logic        to;
    } exp_t;

    exp_t exp_q[$];
    exp_t exp;
    int   checks   = 0;
    int   failures = 0;

    apb3_master_bridge #(
        .NUM_SLAVES    (4),
        .ADDR_WIDTH    (32),
        .DATA_WIDTH    (32),
        .REGION_BITS   (12),
        .TIMEOUT_CYCLES(8)
    ) dut (
        .PCLK       (PCLK),
        .PRESETn    (PRESETn),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_addr   (cmd_addr),
        .cmd_write  (cmd_write),
        .cmd_wdata  (cmd_wdata),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_rdata  (rsp_rdata),
        .rsp_err    (rsp_err),
        .rsp_timeout(rsp_timeout),
        .PSEL       (PSEL),
        .PENABLE    (PENABLE),
        .PADDR      (PADDR),
        .PWRITE     (PWRITE),
        .PWDATA     (PWDATA),
        .PRDATA     (PRDATA),
        .PREADY     (PREADY),
        .PSLVERR    (PSLVERR)
    );

    initial PCLK = 1'b0;
    always #5 PCLK = ~PCLK;

    initial begin
        #100000;
        $display("FAIL watchdog simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge PCLK);
        #1;
    endtask

    task automatic send_cmd(input logic [31:0] a, input logic w, input logic [31:0] d);
        cmd_valid = 1'b1;
        cmd_addr  = a;
        cmd_write = w;
        cmd_wdata = d;
        tick();
        cmd_valid = 1'b0;
    endtask

    // Waits (bounded) for rsp_valid; reports how many cycles it took.
    task automatic wait_rsp(output logic got, output int cyc);
        cyc = 0;
        while (!rsp_valid && cyc < 100) begin
            tick();
            cyc++;
        end
        got = rsp_valid;
    endtask

    task automatic ack_rsp();
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
    endtask

    task automatic test_reset();
        PRESETn   = 1'b0;
        cmd_valid = 1'b0;
        cmd_addr  = '0;
        cmd_write = 1'b0;
        cmd_wdata = '0;
        rsp_ready = 1'b0;
        PRDATA    = {32'h3333_3333, 32'h2222_2222, 32'h1111_1111, 32'h0000_0000};
        PREADY    = 4'b1111;
        PSLVERR   = 4'b0000;
        tick();
        tick();
        checks++;
        if ({PSEL, PENABLE, PWRITE, rsp_valid, rsp_err, rsp_timeout} !== 9'b0) begin
            failures++;
            $display("FAIL reset_ctrl got psel=%b pen=%b pwr=%b rv=%b err=%b to=%b need all 0",
                     PSEL, PENABLE, PWRITE, rsp_valid, rsp_err, rsp_timeout);
        end
        checks++;
        if (PADDR !== 32'h0 || PWDATA !== 32'h0 || rsp_rdata !== 32'h0) begin
            failures++;
            $display("FAIL reset_data got paddr=%h pwdata=%h rdata=%h need 0", PADDR, PWDATA, rsp_rdata);
        end
        checks++;
        if (cmd_ready !== 1'b1) begin
            failures++;
            $display("FAIL reset_cmd_ready got %b need 1", cmd_ready);
        end
        PRESETn = 1'b1;
        tick();
        $display("txn reset done");
    endtask

    task automatic test_write_zero_wait();
        PRDATA[32 +: 32] = 32'hFFFF_FFFF;   // must not leak into a write response
        exp_q.push_back('{rdata: 32'h0, err: 1'b0, to: 1'b0});
        send_cmd(32'h0000_1004, 1'b1, 32'hDEAD_BEEF);
        checks++;
        if (PSEL !== 4'b0010 || PENABLE !== 1'b0 || PADDR !== 32'h0000_1004 ||
            PWRITE !== 1'b1 || PWDATA !== 32'hDEAD_BEEF) begin
            failures++;
            $display("FAIL wr_setup got psel=%b pen=%b paddr=%h pwr=%b pwdata=%h need 0010 0 00001004 1 deadbeef",
                     PSEL, PENABLE, PADDR, PWRITE, PWDATA);
        end
        tick();
        checks++;
        if (PSEL !== 4'b0010 || PENABLE !== 1'b1 || rsp_valid !== 1'b0) begin
            failures++;
            $display("FAIL wr_access got psel=%b pen=%b rv=%b need 0010 1 0", PSEL, PENABLE, rsp_valid);
        end
        tick();
        checks++;
        if (rsp_valid !== 1'b1 || PSEL !== 4'b0000 || PENABLE !== 1'b0) begin
            failures++;
            $display("FAIL wr_latency got rv=%b psel=%b pen=%b need 1 0000 0", rsp_valid, PSEL, PENABLE);
        end
        exp = exp_q.pop_front();
        checks++;
        if (rsp_rdata !== exp.rdata || rsp_err !== exp.err || rsp_timeout !== exp.to) begin
            failures++;
            $display("FAIL wr_rsp got rdata=%h err=%b to=%b need %h %b %b",
                     rsp_rdata, rsp_err, rsp_timeout, exp.rdata, exp.err, exp.to);
        end
        $display("txn write addr=00001004 rdata=%h err=%b to=%b", rsp_rdata, rsp_err, rsp_timeout);
        ack_rsp();
        checks++;
        if (rsp_valid !== 1'b0 || cmd_ready !== 1'b1) begin
            failures++;
            $display("FAIL wr_handshake got rv=%b cmd_ready=%b need 0 1", rsp_valid, cmd_ready);
        end
    endtask

    task automatic test_read_wait();
        int bad = 0;
        PREADY[2]        = 1'b0;
        PSLVERR[2]       = 1'b1;            // ignored while PREADY is low
        PRDATA[64 +: 32] = 32'hBAD0_BAD0;
        PSLVERR[1]       = 1'b1;            // unselected slave, ignored
        exp_q.push_back('{rdata: 32'h1234_5678, err: 1'b0, to: 1'b0});
        send_cmd(32'h0000_2000, 1'b0, 32'h0);
        for (int i = 1; i <= 4; i++) begin
            tick();
            if (PSEL !== 4'b0100 || PENABLE !== 1'b1 || PADDR !== 32'h0000_2000 || rsp_valid !== 1'b0) bad++;
            if (i == 4) begin
                PREADY[2]        = 1'b1;
                PSLVERR[2]       = 1'b0;
                PRDATA[64 +: 32] = 32'h1234_5678;
            end
        end
        checks++;
        if (bad != 0) begin
            failures++;
            $display("FAIL rd_wait_access got %0d bad ACCESS cycles need 0", bad);
        end
        tick();
        checks++;
        if (rsp_valid !== 1'b1 || PSEL !== 4'b0000) begin
            failures++;
            $display("FAIL rd_wait_end got rv=%b psel=%b need 1 0000", rsp_valid, PSEL);
        end
        exp = exp_q.pop_front();
        checks++;
        if (rsp_rdata !== exp.rdata || rsp_err !== exp.err || rsp_timeout !== exp.to) begin
            failures++;
            $display("FAIL rd_wait_rsp got rdata=%h err=%b to=%b need %h %b %b",
                     rsp_rdata, rsp_err, rsp_timeout, exp.rdata, exp.err, exp.to);
        end
        $display("txn read addr=00002000 rdata=%h err=%b to=%b", rsp_rdata, rsp_err, rsp_timeout);
        PSLVERR = 4'b0000;
        ack_rsp();
    endtask

    task automatic test_pslverr();
        logic got;
        int   cyc;
        PRDATA[96 +: 32] = 32'h0;
        PSLVERR[3]       = 1'b1;
        exp_q.push_back('{rdata: 32'h0, err: 1'b1, to: 1'b0});
        send_cmd(32'h0000_3010, 1'b0, 32'h0);
        wait_rsp(got, cyc);
        checks++;
        if (got !== 1'b1 || cyc != 2) begin
            failures++;
            $display("FAIL slverr_latency got valid=%b after %0d cycles need 1 after 2", got, cyc);
        end
        exp = exp_q.pop_front();
        checks++;
        if (rsp_rdata !== exp.rdata || rsp_err !== exp.err || rsp_timeout !== exp.to) begin
            failures++;
            $display("FAIL slverr_rsp got rdata=%h err=%b to=%b need %h %b %b",
                     rsp_rdata, rsp_err, rsp_timeout, exp.rdata, exp.err, exp.to);
        end
        $display("txn read addr=00003010 rdata=%h err=%b to=%b", rsp_rdata, rsp_err, rsp_timeout);
        PSLVERR = 4'b0000;
        ack_rsp();
    endtask

    task automatic test_decode_err();
        exp_q.push_back('{rdata: 32'h0, err: 1'b1, to: 1'b0});
        send_cmd(32'h0000_5000, 1'b1, 32'h1111_2222);
        checks++;
        if (rsp_valid !== 1'b1 || PSEL !== 4'b0000 || PENABLE !== 1'b0) begin
            failures++;
            $display("FAIL decode_err_bus got rv=%b psel=%b pen=%b need 1 0000 0", rsp_valid, PSEL, PENABLE);
        end
        exp = exp_q.pop_front();
        checks++;
        if (rsp_rdata !== exp.rdata || rsp_err !== exp.err || rsp_timeout !== exp.to) begin
            failures++;
            $display("FAIL decode_err_rsp got rdata=%h err=%b to=%b need %h %b %b",
                     rsp_rdata, rsp_err, rsp_timeout, exp.rdata, exp.err, exp.to);
        end
        $display("txn write addr=00005000 rdata=%h err=%b to=%b", rsp_rdata, rsp_err, rsp_timeout);
        ack_rsp();
        checks++;
        if (PSEL !== 4'b0000 || cmd_ready !== 1'b1) begin
            failures++;
            $display("FAIL decode_err_idle got psel=%b cmd_ready=%b need 0000 1", PSEL, cmd_ready);
        end
    endtask

    task automatic test_timeout();
        int bad = 0;
        PREADY[0] = 1'b0;
        exp_q.push_back('{rdata: 32'h0, err: 1'b1, to: 1'b1});
        send_cmd(32'h0000_0040, 1'b0, 32'h0);
        for (int i = 1; i <= 8; i++) begin
            tick();
            if (PSEL !== 4'b0001 || PENABLE !== 1'b1 || rsp_valid !== 1'b0) bad++;
        end
        checks++;
        if (bad != 0) begin
            failures++;
            $display("FAIL timeout_access got %0d bad of 8 ACCESS cycles need 0", bad);
        end
        tick();
        checks++;
        if (PSEL !== 4'b0000 || PENABLE !== 1'b0 || rsp_valid !== 1'b1) begin
            failures++;
            $display("FAIL timeout_abort got psel=%b pen=%b rv=%b need 0000 0 1", PSEL, PENABLE, rsp_valid);
        end
        exp = exp_q.pop_front();
        checks++;
        if (rsp_rdata !== exp.rdata || rsp_err !== exp.err || rsp_timeout !== exp.to) begin
            failures++;
            $display("FAIL timeout_rsp got rdata=%h err=%b to=%b need %h %b %b",
                     rsp_rdata, rsp_err, rsp_timeout, exp.rdata, exp.err, exp.to);
        end
        $display("txn read addr=00000040 rdata=%h err=%b to=%b", rsp_rdata, rsp_err, rsp_timeout);
        ack_rsp();
    endtask

    task automatic test_reset_mid_access();
        int rv_seen = 0;
        send_cmd(32'h0000_0080, 1'b1, 32'hFACE_0001);   // slave0 still not ready
        tick();
        tick();
        checks++;
        if (PENABLE !== 1'b1) begin
            failures++;
            $display("FAIL rst_mid_pre got pen=%b need 1", PENABLE);
        end
        PRESETn = 1'b0;
        tick();
        checks++;
        if (PSEL !== 4'b0 || PENABLE !== 1'b0 || PADDR !== 32'h0 || PWRITE !== 1'b0 ||
            PWDATA !== 32'h0 || rsp_valid !== 1'b0 || rsp_err !== 1'b0 || rsp_timeout !== 1'b0) begin
            failures++;
            $display("FAIL rst_mid_outputs got psel=%b pen=%b paddr=%h pwr=%b pwdata=%h rv=%b err=%b to=%b need all 0",
                     PSEL, PENABLE, PADDR, PWRITE, PWDATA, rsp_valid, rsp_err, rsp_timeout);
        end
        PRESETn   = 1'b1;
        PREADY[0] = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (rsp_valid !== 1'b0 || PSEL !== 4'b0) rv_seen++;
        end
        checks++;
        if (rv_seen != 0 || cmd_ready !== 1'b1) begin
            failures++;
            $display("FAIL rst_mid_after got %0d active cycles cmd_ready=%b need 0 1", rv_seen, cmd_ready);
        end
        $display("txn reset during ACCESS, no response");
    endtask

    task automatic test_back_to_back();
        logic        got;
        int          cyc;
        int          bad = 0;
        PREADY           = 4'b1111;
        PRDATA[32 +: 32] = 32'hA5A5_0001;
        exp_q.push_back('{rdata: 32'hA5A5_0001, err: 1'b0, to: 1'b0});
        send_cmd(32'h0000_1008, 1'b0, 32'h0);
        wait_rsp(got, cyc);
        checks++;
        if (got !== 1'b1 || cyc != 2) begin
            failures++;
            $display("FAIL b2b_first_latency got valid=%b after %0d cycles need 1 after 2", got, cyc);
        end
        exp = exp_q.pop_front();
        checks++;
        if (rsp_rdata !== exp.rdata || rsp_err !== exp.err || rsp_timeout !== exp.to) begin
            failures++;
            $display("FAIL b2b_first_rsp got rdata=%h err=%b to=%b need %h %b %b",
                     rsp_rdata, rsp_err, rsp_timeout, exp.rdata, exp.err, exp.to);
        end
        $display("txn read addr=00001008 rdata=%h err=%b to=%b", rsp_rdata, rsp_err, rsp_timeout);
        // Next command waits while the response is back-pressured.
        PRDATA[32 +: 32] = 32'h0F0F_0F0F;
        cmd_valid = 1'b1;
        cmd_addr  = 32'h0000_2004;
        cmd_write = 1'b1;
        cmd_wdata = 32'h0000_55AA;
        exp_q.push_back('{rdata: 32'h0, err: 1'b0, to: 1'b0});
        for (int i = 0; i < 5; i++) begin
            tick();
            if (rsp_valid !== 1'b1 || rsp_rdata !== 32'hA5A5_0001 || cmd_ready !== 1'b0 || PSEL !== 4'b0) bad++;
        end
        checks++;
        if (bad != 0) begin
            failures++;
            $display("FAIL b2b_backpressure got %0d unstable cycles of 5 need 0", bad);
        end
        rsp_ready = 1'b1;
        tick();
        checks++;
        if (rsp_valid !== 1'b0 || cmd_ready !== 1'b1) begin
            failures++;
            $display("FAIL b2b_release got rv=%b cmd_ready=%b need 0 1", rsp_valid, cmd_ready);
        end
        tick();
        cmd_valid = 1'b0;
        checks++;
        if (PSEL !== 4'b0100 || PWRITE !== 1'b1 || PWDATA !== 32'h0000_55AA) begin
            failures++;
            $display("FAIL b2b_second_setup got psel=%b pwr=%b pwdata=%h need 0100 1 000055aa", PSEL, PWRITE, PWDATA);
        end
        wait_rsp(got, cyc);
        exp = exp_q.pop_front();
        checks++;
        if (got !== 1'b1 || cyc != 2 || rsp_rdata !== exp.rdata || rsp_err !== exp.err || rsp_timeout !== exp.to) begin
            failures++;
            $display("FAIL b2b_second_rsp got valid=%b cyc=%0d rdata=%h err=%b to=%b need 1 2 %h %b %b",
                     got, cyc, rsp_rdata, rsp_err, rsp_timeout, exp.rdata, exp.err, exp.to);
        end
        $display("txn write addr=00002004 rdata=%h err=%b to=%b", rsp_rdata, rsp_err, rsp_timeout);
        tick();
        PRDATA[0 +: 32] = 32'h0BAD_C0DE;
        exp_q.push_back('{rdata: 32'h0BAD_C0DE, err: 1'b0, to: 1'b0});
        checks++;
        if (cmd_ready !== 1'b1) begin
            failures++;
            $display("FAIL b2b_third_ready got cmd_ready=%b need 1", cmd_ready);
        end
        send_cmd(32'h0000_0000, 1'b0, 32'h0);
        wait_rsp(got, cyc);
        exp = exp_q.pop_front();
        checks++;
        if (got !== 1'b1 || rsp_rdata !== exp.rdata || rsp_err !== exp.err || rsp_timeout !== exp.to) begin
            failures++;
            $display("FAIL b2b_third_rsp got valid=%b rdata=%h err=%b to=%b need 1 %h %b %b",
                     got, rsp_rdata, rsp_err, rsp_timeout, exp.rdata, exp.err, exp.to);
        end
        $display("txn read addr=00000000 rdata=%h err=%b to=%b", rsp_rdata, rsp_err, rsp_timeout);
        tick();
        rsp_ready = 1'b0;
    endtask

    initial begin
        test_reset();
        test_write_zero_wait();
        test_read_wait();
        test_pslverr();
        test_decode_err();
        test_timeout();
        test_reset_mid_access();
        test_back_to_back();
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain got %0d pending need 0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
